// File: rtl/coax_tx_scheduler_if.sv
// rtl/coax_tx_scheduler_if.sv - requester and transmitter signal bundle for coax_tx_scheduler
interface coax_tx_scheduler_if;
    logic       req0_valid;
    logic [9:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [9:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [1:0] grant;
    logic       tx_start;
    logic [9:0] tx_data;
    logic       tx_data_valid;
    logic       tx_load;
    logic       tx_active;
    logic       busy;
    logic       underflow;

    modport master (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_load, tx_active,
        output req0_ready, req1_ready, grant,
        output tx_start, tx_data, tx_data_valid,
        output busy, underflow
    );

    modport slave (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_load, tx_active,
        input  req0_ready, req1_ready, grant,
        input  tx_start, tx_data, tx_data_valid,
        input  busy, underflow
    );
endinterface

// File: rtl/coax_tx_scheduler.sv
// rtl/coax_tx_scheduler.sv - two-requester frame scheduler for the coax transmitter (option macro: COAX_TX_SCHED_PRIORITY_EN)
module coax_tx_scheduler #(
    parameter int MAX_WORDS  = 64,
    parameter int GAP_CLOCKS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    coax_tx_scheduler_if.master bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int GW = (GAP_CLOCKS > 1) ? $clog2(GAP_CLOCKS) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    ready_q, ready_d;
    logic          tx_start_q, tx_start_d;
    logic [9:0]    tx_data_q, tx_data_d;
    logic          tx_data_valid_q, tx_data_valid_d;
    logic          last_q, last_d;
    logic          end_capt_q, end_capt_d;
    logic          busy_q, busy_d;
    logic          underflow_q, underflow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          seen_active_q, seen_active_d;
    logic          sel_valid;
    logic [9:0]    sel_data;
    logic          sel_last;
    logic          pick1;
    logic [CW-1:0] cnt_inc;

    // Requester currently owning the frame.
    assign sel_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
    assign sel_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
    assign sel_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;
    assign cnt_inc   = cnt_q + CW'(1);

`ifdef COAX_TX_SCHED_PRIORITY_EN
    // Requester 0 wins whenever it is valid.
    assign pick1 = !bus.req0_valid;
`else
    logic rr_q, rr_d;

    // rr_q names the requester favoured when both are valid.
    assign pick1 = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
`endif

    // Frame sequencing, arbitration and holding-register control.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ready_d         = 2'b00;
        tx_start_d      = 1'b0;
        tx_data_d       = tx_data_q;
        tx_data_valid_d = tx_data_valid_q;
        last_d          = last_q;
        end_capt_d      = end_capt_q;
        underflow_d     = 1'b0;
        cnt_d           = cnt_q;
        gap_d           = gap_q;
        seen_active_d   = seen_active_q;
`ifndef COAX_TX_SCHED_PRIORITY_EN
        rr_d            = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d = S_FETCH;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    ready_d = pick1 ? 2'b10 : 2'b01;
`ifndef COAX_TX_SCHED_PRIORITY_EN
                    rr_d    = !pick1;
`endif
                end
            end
            S_FETCH: begin
                tx_data_d       = sel_data;
                last_d          = sel_last;
                tx_data_valid_d = 1'b1;
                cnt_d           = CW'(1);
                end_capt_d      = sel_last || (MAX_WORDS == 1);
                tx_start_d      = 1'b1;
                state_d         = S_START;
            end
            S_START: begin
                tx_data_valid_d = 1'b0;
                seen_active_d   = 1'b0;
                state_d         = end_capt_q ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                if (bus.tx_active) begin
                    seen_active_d = 1'b1;
                end
                if (ready_q != 2'b00) begin
                    // Ready is out this cycle, so the requester word is taken now.
                    tx_data_d       = sel_data;
                    last_d          = sel_last;
                    tx_data_valid_d = 1'b1;
                    cnt_d           = cnt_inc;
                    end_capt_d      = sel_last || (cnt_inc == MAX_CNT);
                end else if (!bus.tx_load && !tx_data_valid_q && !end_capt_q && sel_valid) begin
                    ready_d = grant_q;
                end
                if (bus.tx_load) begin
                    if (tx_data_valid_q) begin
                        tx_data_valid_d = 1'b0;
                        if (last_q || (cnt_q == MAX_CNT)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        // A word captured in this same cycle is never offered.
                        tx_data_valid_d = 1'b0;
                        underflow_d     = 1'b1;
                        state_d         = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.tx_active) begin
                    seen_active_d = 1'b1;
                end else if (seen_active_q) begin
                    state_d = S_GAP;
                    grant_d = 2'b00;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            grant_q         <= 2'b00;
            ready_q         <= 2'b00;
            tx_start_q      <= 1'b0;
            tx_data_q       <= '0;
            tx_data_valid_q <= 1'b0;
            last_q          <= 1'b0;
            end_capt_q      <= 1'b0;
            busy_q          <= 1'b0;
            underflow_q     <= 1'b0;
            cnt_q           <= '0;
            gap_q           <= '0;
            seen_active_q   <= 1'b0;
`ifndef COAX_TX_SCHED_PRIORITY_EN
            rr_q            <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            ready_q         <= ready_d;
            tx_start_q      <= tx_start_d;
            tx_data_q       <= tx_data_d;
            tx_data_valid_q <= tx_data_valid_d;
            last_q          <= last_d;
            end_capt_q      <= end_capt_d;
            busy_q          <= busy_d;
            underflow_q     <= underflow_d;
            cnt_q           <= cnt_d;
            gap_q           <= gap_d;
            seen_active_q   <= seen_active_d;
`ifndef COAX_TX_SCHED_PRIORITY_EN
            rr_q            <= rr_d;
`endif
        end
    end

    assign bus.req0_ready    = ready_q[0];
    assign bus.req1_ready    = ready_q[1];
    assign bus.grant         = grant_q;
    assign bus.tx_start      = tx_start_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = tx_data_valid_q;
    assign bus.busy          = busy_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_coax_tx_scheduler.sv
// tb/tb_coax_tx_scheduler.sv - self-checking bench for coax_tx_scheduler
module tb_coax_tx_scheduler;
    localparam int MAXW = 4;
    localparam int GAP  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    coax_tx_scheduler_if bus();

    coax_tx_scheduler #(.MAX_WORDS(MAXW), .GAP_CLOCKS(GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // requester word queues: bit 10 is the last flag
    logic [10:0] q0[$];
    logic [10:0] q1[$];

    int r0_cnt = 0;
    int r1_cnt = 0;
    int uf_cnt = 0;

    // results of the most recent transmitter frame
    logic [9:0] got_q[$];
    logic [1:0] got_grant;
    int         busy_lat;
    bit         tmo;
    bit         early;

    always @(negedge clk) begin
        if (bus.req0_ready === 1'b1) r0_cnt <= r0_cnt + 1;
        if (bus.req1_ready === 1'b1) r1_cnt <= r1_cnt + 1;
        if (bus.underflow === 1'b1) uf_cnt <= uf_cnt + 1;
    end

    // Requesters: present the queue front, pop on each ready pulse.
    initial begin : req_driver
        logic take0, take1;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
        forever begin
            @(negedge clk);
            take0 = bus.req0_ready;
            take1 = bus.req1_ready;
            @(posedge clk);
            #1;
            if (take0 && q0.size() > 0) void'(q0.pop_front());
            if (take1 && q1.size() > 0) void'(q1.pop_front());
            bus.req0_valid = (q0.size() > 0);
            bus.req0_data  = (q0.size() > 0) ? q0[0][9:0] : 10'h000;
            bus.req0_last  = (q0.size() > 0) ? q0[0][10]  : 1'b0;
            bus.req1_valid = (q1.size() > 0);
            bus.req1_data  = (q1.size() > 0) ? q1[0][9:0] : 10'h000;
            bus.req1_last  = (q1.size() > 0) ? q1[0][10]  : 1'b0;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        bus.tx_load = 1'b0;
        bus.tx_active = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: latch first word at tx_start, load until the holding
    // register is empty, then drop tx_active and time the fall of busy.
    task automatic run_frame(input int sp_lo, input int sp_hi, input int act_dly);
        int n;
        logic v;
        logic [9:0] d;
        got_q.delete();
        tmo = 0; early = 0; busy_lat = -1; got_grant = 2'b00;
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 400) begin
            tmo = 1;
            return;
        end
        got_grant = bus.grant;
        got_q.push_back(bus.tx_data);
        for (int k = 0; k < act_dly; k++) begin
            @(posedge clk); #1;
            if (bus.grant === 2'b00 || bus.busy !== 1'b1) early = 1;
        end
        bus.tx_active = 1'b1;
        n = 0;
        while (n < 64) begin
            repeat ($urandom_range(sp_hi, sp_lo)) @(posedge clk);
            #1;
            bus.tx_load = 1'b1;
            v = bus.tx_data_valid;
            d = bus.tx_data;
            @(posedge clk); #1;
            bus.tx_load = 1'b0;
            if (v !== 1'b1) break;
            got_q.push_back(d);
            n++;
        end
        @(posedge clk); #1;
        bus.tx_active = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        busy_lat = n;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.tx_load = 1'b0;
        bus.tx_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.grant, bus.req1_ready, bus.req0_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_grant_ready got %b exp 0000", {bus.grant, bus.req1_ready, bus.req0_ready});
        end
        checks++;
        if ({bus.tx_start, bus.tx_data_valid, bus.tx_data} !== 12'h000) begin
            errors++; $display("FAIL reset_tx got %h exp 000", {bus.tx_start, bus.tx_data_valid, bus.tx_data});
        end
        checks++;
        if ({bus.busy, bus.underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_uf got %b exp 00", {bus.busy, bus.underflow});
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        int rb0, ub;
        do_reset();
        q0.push_back({1'b0, 10'h101});
        q0.push_back({1'b0, 10'h0A5});
        q0.push_back({1'b1, 10'h3FF});
        rb0 = r0_cnt; ub = uf_cnt;
        run_frame(80, 80, 0);
        checks++;
        if (tmo) begin errors++; $display("FAIL single_timeout got timeout exp tx_start"); end
        checks++;
        if (got_grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", got_grant); end
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL single_count got %0d exp 3", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 10'h101) begin errors++; $display("FAIL single_w0 got %h exp 101", got_q[0]); end
            checks++;
            if (got_q[1] !== 10'h0A5) begin errors++; $display("FAIL single_w1 got %h exp 0a5", got_q[1]); end
            checks++;
            if (got_q[2] !== 10'h3FF) begin errors++; $display("FAIL single_w2 got %h exp 3ff", got_q[2]); end
        end
        checks++;
        if (r0_cnt - rb0 != 3) begin errors++; $display("FAIL single_ready0 got %0d exp 3", r0_cnt - rb0); end
        checks++;
        if (uf_cnt != ub) begin errors++; $display("FAIL single_underflow got %0d exp 0", uf_cnt - ub); end
        checks++;
        if (busy_lat != GAP + 1) begin errors++; $display("FAIL single_busy_fall got %0d exp %0d", busy_lat, GAP + 1); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g[4];
        logic [9:0] exp_d[4];
        do_reset();
`ifdef COAX_TX_SCHED_PRIORITY_EN
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10};
        exp_d = '{10'h011, 10'h012, 10'h021, 10'h022};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{10'h011, 10'h021, 10'h012, 10'h022};
`endif
        q0.push_back({1'b1, 10'h011});
        q0.push_back({1'b1, 10'h012});
        q1.push_back({1'b1, 10'h021});
        q1.push_back({1'b1, 10'h022});
        for (int f = 0; f < 4; f++) begin
            run_frame(6, 10, 0);
            checks++;
            if (tmo || got_grant !== exp_g[f]) begin
                errors++; $display("FAIL b2b_grant%0d got %b exp %b (timeout %0d)", f, got_grant, exp_g[f], tmo);
            end
            checks++;
            if (got_q.size() != 1 || got_q[0] !== exp_d[f]) begin
                errors++; $display("FAIL b2b_data%0d got %h (n=%0d) exp %h", f, (got_q.size() > 0) ? got_q[0] : 10'h000, got_q.size(), exp_d[f]);
            end
        end
    endtask

    task automatic test_underflow();
        int rb1, ub;
        do_reset();
        q1.push_back({1'b0, 10'h155});
        rb1 = r1_cnt; ub = uf_cnt;
        run_frame(8, 8, 0);
        checks++;
        if (tmo || got_grant !== 2'b10) begin errors++; $display("FAIL uf_grant got %b exp 10 (timeout %0d)", got_grant, tmo); end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL uf_words got %0d exp 1", got_q.size()); end
        checks++;
        if (uf_cnt - ub != 1) begin errors++; $display("FAIL uf_pulses got %0d exp 1", uf_cnt - ub); end
        checks++;
        if (busy_lat != GAP + 1) begin errors++; $display("FAIL uf_busy_fall got %0d exp %0d", busy_lat, GAP + 1); end
        checks++;
        if (bus.grant !== 2'b00) begin errors++; $display("FAIL uf_grant_idle got %b exp 00", bus.grant); end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (r1_cnt - rb1 != 1) begin errors++; $display("FAIL uf_ready1 got %0d exp 1", r1_cnt - rb1); end
    endtask

    task automatic test_max_words();
        int rb0, ub;
        do_reset();
        for (int i = 0; i < 6; i++) q0.push_back({1'b0, 10'(10'h200 + i)});
        rb0 = r0_cnt; ub = uf_cnt;
        run_frame(7, 12, 0);
        checks++;
        if (tmo || got_q.size() != MAXW) begin errors++; $display("FAIL max_frame1_len got %0d exp %0d", got_q.size(), MAXW); end
        checks++;
        if (got_q.size() != MAXW || got_q[MAXW-1] !== 10'h203) begin
            errors++; $display("FAIL max_frame1_tail got %h exp 203", (got_q.size() > 0) ? got_q[got_q.size()-1] : 10'h000);
        end
        checks++;
        if (uf_cnt != ub || r0_cnt - rb0 != MAXW) begin
            errors++; $display("FAIL max_frame1_ctl got uf %0d rdy %0d exp uf 0 rdy %0d", uf_cnt - ub, r0_cnt - rb0, MAXW);
        end
        run_frame(7, 12, 0);
        checks++;
        if (tmo || got_q.size() != 2 || got_q[0] !== 10'h204 || got_q[1] !== 10'h205) begin
            errors++; $display("FAIL max_frame2 got n=%0d first %h exp n=2 first 204", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h000);
        end
        checks++;
        if (uf_cnt - ub != 1) begin errors++; $display("FAIL max_frame2_uf got %0d exp 1", uf_cnt - ub); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back({1'b0, 10'(10'h111 + i)});
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        bus.tx_active = 1'b1;
        while (!(bus.tx_data_valid === 1'b1 && bus.tx_start === 1'b0) && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL areset_reach_stream got timeout exp refill"); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.grant, bus.req1_ready, bus.req0_ready, bus.tx_start, bus.tx_data_valid, bus.tx_data, bus.busy, bus.underflow} !== 18'h0) begin
            errors++; $display("FAIL areset_outputs got %h exp 0", {bus.grant, bus.req1_ready, bus.req0_ready, bus.tx_start, bus.tx_data_valid, bus.tx_data, bus.busy, bus.underflow});
        end
        q0.delete(); q1.delete();
        bus.tx_active = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        q0.push_back({1'b1, 10'h0C3});
        q1.push_back({1'b1, 10'h3C0});
        run_frame(6, 6, 0);
        checks++;
        if (tmo || got_grant !== 2'b01 || got_q.size() == 0 || got_q[0] !== 10'h0C3) begin
            errors++; $display("FAIL areset_fresh_grant got %b/%h exp 01/0c3", got_grant, (got_q.size() > 0) ? got_q[0] : 10'h000);
        end
        run_frame(6, 6, 0);
        checks++;
        if (tmo || got_grant !== 2'b10) begin errors++; $display("FAIL areset_second_grant got %b exp 10", got_grant); end
    endtask

    task automatic test_start_latency();
        do_reset();
        q0.push_back({1'b1, 10'h2AA});
        run_frame(8, 8, 3);
        checks++;
        if (tmo || early) begin errors++; $display("FAIL lat_early_gap got early=%0d timeout=%0d exp 0", early, tmo); end
        checks++;
        if (got_grant !== 2'b01 || got_q.size() != 1 || got_q[0] !== 10'h2AA) begin
            errors++; $display("FAIL lat_frame got %b n=%0d exp 01 n=1", got_grant, got_q.size());
        end
        checks++;
        if (busy_lat != GAP + 1) begin errors++; $display("FAIL lat_busy_fall got %0d exp %0d", busy_lat, GAP + 1); end
    endtask

    // Random frame mixes checked against a queue-level model of arbitration
    // and frame termination (last word, word limit, requester running dry).
    task automatic test_random();
        logic [10:0] m0[$];
        logic [10:0] m1[$];
        logic [10:0] w;
        logic [9:0]  exp_q[$];
        logic        fav, pick, lastseen;
        int          nw, frames, rb0, rb1, ub, exp_uf;
        for (int trial = 0; trial < 3; trial++) begin
            do_reset();
            fav = 1'b0;
            m0.delete(); m1.delete();
            nw = $urandom_range(8, 2);
            for (int i = 0; i < nw; i++) begin
                w = {($urandom_range(2, 0) == 0), 10'($urandom)};
                q0.push_back(w); m0.push_back(w);
            end
            nw = $urandom_range(8, 2);
            for (int i = 0; i < nw; i++) begin
                w = {($urandom_range(2, 0) == 0), 10'($urandom)};
                q1.push_back(w); m1.push_back(w);
            end
            frames = 0;
            while ((m0.size() > 0 || m1.size() > 0) && frames < 40) begin
                if (m0.size() > 0 && m1.size() > 0) begin
`ifdef COAX_TX_SCHED_PRIORITY_EN
                    pick = 1'b0;
`else
                    pick = fav;
`endif
                end else begin
                    pick = (m1.size() > 0);
                end
                fav = ~pick;
                exp_q.delete();
                lastseen = 1'b0;
                while (!lastseen && exp_q.size() < MAXW && (pick ? m1.size() : m0.size()) > 0) begin
                    if (pick) w = m1.pop_front();
                    else      w = m0.pop_front();
                    exp_q.push_back(w[9:0]);
                    lastseen = w[10];
                end
                exp_uf = (!lastseen && exp_q.size() < MAXW) ? 1 : 0;
                rb0 = r0_cnt; rb1 = r1_cnt; ub = uf_cnt;
                run_frame(6, 14, $urandom_range(2, 0));
                checks++;
                if (tmo || got_grant !== (pick ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rand_grant t%0d f%0d got %b exp %b (timeout %0d)", trial, frames, got_grant, pick ? 2'b10 : 2'b01, tmo);
                    break;
                end
                checks++;
                if (got_q != exp_q) begin
                    errors++; $display("FAIL rand_words t%0d f%0d got n=%0d exp n=%0d", trial, frames, got_q.size(), exp_q.size());
                end
                checks++;
                if (uf_cnt - ub != exp_uf) begin
                    errors++; $display("FAIL rand_underflow t%0d f%0d got %0d exp %0d", trial, frames, uf_cnt - ub, exp_uf);
                end
                checks++;
                if ((pick ? r1_cnt - rb1 : r0_cnt - rb0) != exp_q.size() || (pick ? r0_cnt - rb0 : r1_cnt - rb1) != 0) begin
                    errors++; $display("FAIL rand_ready t%0d f%0d got r0 %0d r1 %0d exp %0d on req%0d", trial, frames, r0_cnt - rb0, r1_cnt - rb1, exp_q.size(), pick);
                end
                checks++;
                if (busy_lat != GAP + 1) begin
                    errors++; $display("FAIL rand_busy_fall t%0d f%0d got %0d exp %0d", trial, frames, busy_lat, GAP + 1);
                end
                frames++;
            end
            checks++;
            if (q0.size() + q1.size() != 0) begin
                errors++; $display("FAIL rand_leftover t%0d got %0d words exp 0", trial, q0.size() + q1.size());
            end
        end
    endtask

    initial begin
        bus.tx_load = 1'b0;
        bus.tx_active = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underflow();
        test_max_words();
        test_async_reset();
        test_start_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
